i2s_tx: RTL and testbench
=========================

// Module: i2s_tx
// PURPOSE
//  I2S transmitter, the output-side counterpart of the mic receive path. It takes
//  16-bit stereo PCM pairs over a valid/ready handshake and generates the BCLK,
//  LRCLK and SDATA signals for an external I2S DAC/amp on a PMOD. It runs in the
//  98.304 MHz audio clock domain; with the defaults that is BCLK 3.072 MHz and
//  LRCLK 48 kHz, matching the mic clocks.
// PARAMETERS
//  BCLK_DIV      32  clk_in cycles per BCLK period; even, >=4
//  SAMPLE_WIDTH  16  bits per channel sample
//  SLOT_WIDTH    32  BCLK periods per channel slot; >= SAMPLE_WIDTH+1
// PORTS
//  clk_in            in   1             audio clock (98.304 MHz)
//  rst_n_in          in   1             async reset, active-low
//  sample_left_in    in   SAMPLE_WIDTH  left sample, two's complement
//  sample_right_in   in   SAMPLE_WIDTH  right sample, two's complement
//  sample_valid_in   in   1             stereo pair offered
//  sample_ready_out  out  1             staging register empty; pair accepted when valid&ready
//  i2s_bclk_out      out  1             bit clock
//  i2s_lrcl_out      out  1             word select: 0=left, 1=right
//  i2s_data_out      out  1             serial data, MSB first
//  frame_start_out   out  1             1-cycle pulse when a frame loads
//  underrun_out      out  1             1-cycle pulse when a frame loads with no staged pair
// BEHAVIOUR
//  - Reset is one clock domain, asynchronous, active-low (rst_n_in). It clears
//    div_cnt=0, bit_cnt=0, the staging register to empty, and the shift data to 0.
//    Output reset values: bclk=0, lrcl=0, data=0, ready=1, frame_start=0, underrun=0.
//    Asserting reset mid-frame takes effect immediately and discards the staged pair.
//  - div_cnt counts 0..BCLK_DIV-1 and wraps. bclk_out=1 when div_cnt>=BCLK_DIV/2.
//    A BCLK fall is the div_cnt wrap edge.
//  - bit_cnt counts 0..2*SLOT_WIDTH-1. It advances only on the div_cnt wrap and
//    wraps from 2*SLOT_WIDTH-1 to 0.
//  - All outputs are registered. lrcl_out and data_out update on the same clk_in
//    edge as the BCLK fall, so they are stable for BCLK_DIV/2 cycles before the
//    BCLK rise.
//  - lrcl_out=1 for bit_cnt in [SLOT_WIDTH-1, 2*SLOT_WIDTH-2], else 0. This
//    transitions LRCLK one BCLK before each MSB (I2S standard).
//  - data_out mapping:
//      bit_cnt=i (i<SAMPLE_WIDTH)            -> left[SAMPLE_WIDTH-1-i]
//      bit_cnt=SLOT_WIDTH+i (i<SAMPLE_WIDTH) -> right[SAMPLE_WIDTH-1-i]
//      all other slot bits                   -> 0
//  - Frame load happens on the edge where bit_cnt wraps to 0. The transmit data
//    takes the staging register contents as they were before that edge. If
//    staging is full it is marked empty; if empty, both channels send 0 and
//    underrun_out pulses. frame_start_out pulses on every load.
//  - The first frame after reset (bit_cnt starting at 0) transmits zeros. It is
//    not a load, so there is no frame_start pulse and no underrun pulse.
//  - Handshake: sample_ready_out = staging empty. Accept on the edge where
//    valid&ready. Inputs are ignored while ready=0. valid need not be held.
//  - Simultaneous accept and load: if staging is empty at a load edge and valid=1,
//    the pair is captured into staging for the NEXT frame. The current frame still
//    underruns, and ready goes low after that edge.
//  - Latency: a pair accepted at least 1 cycle before a load edge is serialised in
//    that frame. Its left MSB appears on data_out at the load edge.
// TESTING
//  1. Reset release, no valid for 3 frames:
//     bclk period 32 cycles, lrcl period 2048 cycles, first lrcl rise at cycle 31*32;
//     data=0 throughout; underrun pulses at cycles 2048 and 4096; no pulse at cycle 0.
//  2. Before 1st load, send L=16'hA5C3, R=16'h0F01:
//     frame 2 left slot bits 0..15 = 1010_0101_1100_0011, bits 16..31 = 0;
//     right slot = 0000_1111_0000_0001; no underrun.
//  3. Backpressure: hold valid=1 with changing data:
//     ready drops after accept, ready=1 only for 1 cycle after each load edge;
//     exactly one pair per frame is transmitted, in order.
//  4. Offer valid for the first time on the load-edge cycle:
//     that frame underruns and sends zeros; the pair appears in the following frame.
//  5. Assert rst_n_in low mid right slot (bit_cnt=40) with a pair staged:
//     all outputs go to reset values immediately; after release the staged pair is
//     never transmitted.
//  6. BCLK_DIV=4, SLOT_WIDTH=24, L=16'h8001:
//     bclk period 4 cycles, lrcl period 192 cycles, MSB=1 at left bit 0, LSB=1 at
//     bit 15, bits 16..23 = 0.

Source files
------------

// File: rtl/i2s_tx_if.sv
// Stereo PCM sample handshake into the I2S transmitter.
// valid/ready: a pair transfers on the clock edge where sample_valid_in & sample_ready_out are both 1.
interface i2s_tx_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic [SAMPLE_WIDTH-1:0] sample_left_in;
    logic [SAMPLE_WIDTH-1:0] sample_right_in;
    logic                    sample_valid_in;
    logic                    sample_ready_out;

    modport master (
        output sample_left_in,
        output sample_right_in,
        output sample_valid_in,
        input  sample_ready_out
    );

    modport slave (
        input  sample_left_in,
        input  sample_right_in,
        input  sample_valid_in,
        output sample_ready_out
    );
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep staging register feeding a frame shift register,
// with BCLK/LRCLK/SDATA generated from a clock divider and a slot bit counter.
module i2s_tx #(
    parameter int BCLK_DIV     = 32,
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 32
) (
    input  logic     clk_in,
    input  logic     rst_n_in,
    i2s_tx_if.slave  smp,
    output logic     i2s_bclk_out,
    output logic     i2s_lrcl_out,
    output logic     i2s_data_out,
    output logic     frame_start_out,
    output logic     underrun_out
);
    localparam int DW   = $clog2(BCLK_DIV);
    localparam int FW   = 2 * SLOT_WIDTH;
    localparam int CW   = $clog2(FW);
    localparam int PADW = SLOT_WIDTH - SAMPLE_WIDTH;

    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
    localparam logic [CW-1:0] BIT_LAST = CW'(FW - 1);
    localparam logic [CW-1:0] LR_FIRST = CW'(SLOT_WIDTH - 1);
    localparam logic [CW-1:0] LR_LAST  = CW'(FW - 2);

    logic [DW-1:0]           div_cnt_q, div_cnt_d;
    logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
    logic                    stage_full_q, stage_full_d;
    logic [SAMPLE_WIDTH-1:0] stage_left_q, stage_left_d;
    logic [SAMPLE_WIDTH-1:0] stage_right_q, stage_right_d;
    logic [FW-1:0]           frame_q, frame_d;
    logic                    bclk_q, bclk_d;
    logic                    lrcl_q, lrcl_d;
    logic                    ready_q, ready_d;
    logic                    frame_start_q, frame_start_d;
    logic                    underrun_q, underrun_d;

    logic bclk_fall;
    logic load;
    logic accept;

    always_comb begin
        bclk_fall = (div_cnt_q == DIV_LAST);
        load      = bclk_fall && (bit_cnt_q == BIT_LAST);
        accept    = smp.sample_valid_in && ready_q;

        div_cnt_d = bclk_fall ? '0 : div_cnt_q + DW'(1);
        bit_cnt_d = bit_cnt_q;
        if (bclk_fall) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + CW'(1);
        end

        stage_full_d  = stage_full_q;
        stage_left_d  = stage_left_q;
        stage_right_d = stage_right_q;
        frame_d       = frame_q;

        // The frame register holds the whole frame in slot order; its MSB is the wire.
        if (load) begin
            frame_d = '0;
            if (stage_full_q) begin
                frame_d = {stage_left_q, {PADW{1'b0}}, stage_right_q, {PADW{1'b0}}};
            end
            stage_full_d = 1'b0;
        end else if (bclk_fall) begin
            frame_d = {frame_q[FW-2:0], 1'b0};
        end

        // An accept on a load edge refills staging for the following frame.
        if (accept) begin
            stage_full_d  = 1'b1;
            stage_left_d  = smp.sample_left_in;
            stage_right_d = smp.sample_right_in;
        end

        bclk_d        = (div_cnt_d >= DIV_HALF);
        lrcl_d        = (bit_cnt_d >= LR_FIRST) && (bit_cnt_d <= LR_LAST);
        ready_d       = !stage_full_d;
        frame_start_d = load;
        underrun_d    = load && !stage_full_q;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            div_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            stage_full_q  <= 1'b0;
            stage_left_q  <= '0;
            stage_right_q <= '0;
            frame_q       <= '0;
            bclk_q        <= 1'b0;
            lrcl_q        <= 1'b0;
            ready_q       <= 1'b1;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            stage_full_q  <= stage_full_d;
            stage_left_q  <= stage_left_d;
            stage_right_q <= stage_right_d;
            frame_q       <= frame_d;
            bclk_q        <= bclk_d;
            lrcl_q        <= lrcl_d;
            ready_q       <= ready_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign smp.sample_ready_out = ready_q;
    assign i2s_bclk_out         = bclk_q;
    assign i2s_lrcl_out         = lrcl_q;
    assign i2s_data_out         = frame_q[FW-1];
    assign frame_start_out      = frame_start_q;
    assign underrun_out         = underrun_q;
endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: two instances (default timing and BCLK_DIV=4/SLOT_WIDTH=24)
// checked every cycle against a frame-level model plus captured-frame tables.
module tb_i2s_tx;
  localparam int SW    = 16;
  localparam int FL_A  = 2 * 32 * 32;
  localparam int FL_B  = 2 * 4 * 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2s_tx_if #(.SAMPLE_WIDTH(SW)) if_a ();
  i2s_tx_if #(.SAMPLE_WIDTH(SW)) if_b ();
  logic bclk_a, lrcl_a, data_a, fs_a, ur_a;
  logic bclk_b, lrcl_b, data_b, fs_b, ur_b;

  i2s_tx #(.BCLK_DIV(32), .SAMPLE_WIDTH(SW), .SLOT_WIDTH(32)) dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .smp(if_a.slave),
    .i2s_bclk_out(bclk_a), .i2s_lrcl_out(lrcl_a), .i2s_data_out(data_a),
    .frame_start_out(fs_a), .underrun_out(ur_a)
  );

  i2s_tx #(.BCLK_DIV(4), .SAMPLE_WIDTH(SW), .SLOT_WIDTH(24)) dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .smp(if_b.slave),
    .i2s_bclk_out(bclk_b), .i2s_lrcl_out(lrcl_b), .i2s_data_out(data_b),
    .frame_start_out(fs_b), .underrun_out(ur_b)
  );

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic [63:0] exp_frame;
  } vec_t;
  vec_t tbl [4];

  int errors = 0;
  int checks = 0;

  // reference model state, index 0 = dut_a, 1 = dut_b
  int          div_p [2] = '{32, 4};
  int          slot_p [2] = '{32, 24};
  int          t [2];
  logic        m_full [2];
  logic [15:0] m_sl [2], m_sr [2], cur_l [2], cur_r [2];
  logic        fs_e [2], ur_e [2];
  logic [63:0] cap [2];
  logic [63:0] got [2][8];
  int          ur_cnt [2], fs_cnt [2];
  int          first_lr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp_v);
    end
  endtask

  function automatic logic [5:0] exp_out(input int d);
    int b, dv, sl;
    logic bc, lr, dt;
    dv = div_p[d];
    sl = slot_p[d];
    b  = (t[d] / dv) % (2 * sl);
    bc = (t[d] % dv) >= dv / 2;
    lr = (b >= sl - 1) && (b <= 2 * sl - 2);
    if (b < SW) dt = cur_l[d][SW-1-b];
    else if (b >= sl && b < sl + SW) dt = cur_r[d][SW-1-(b-sl)];
    else dt = 1'b0;
    return {bc, lr, dt, !m_full[d], fs_e[d], ur_e[d]};
  endfunction

  task automatic model_edge(input int d, input logic v, input logic [15:0] l, input logic [15:0] r);
    int fl;
    logic acc;
    fl = 2 * div_p[d] * slot_p[d];
    t[d]++;
    acc = v && !m_full[d];
    fs_e[d] = 1'b0;
    ur_e[d] = 1'b0;
    if (t[d] % fl == 0) begin
      fs_e[d]  = 1'b1;
      ur_e[d]  = !m_full[d];
      cur_l[d] = m_full[d] ? m_sl[d] : 16'h0;
      cur_r[d] = m_full[d] ? m_sr[d] : 16'h0;
      m_full[d] = 1'b0;
    end
    if (acc) begin
      m_full[d] = 1'b1;
      m_sl[d] = l;
      m_sr[d] = r;
    end
  endtask

  function automatic logic [5:0] dut_out(input int d);
    if (d == 0) return {bclk_a, lrcl_a, data_a, if_a.sample_ready_out, fs_a, ur_a};
    return {bclk_b, lrcl_b, data_b, if_b.sample_ready_out, fs_b, ur_b};
  endfunction

  task automatic step();
    logic va, vb;
    logic [15:0] la, ra, lb, rb;
    logic [5:0] o, e;
    int dv, fl;
    va = if_a.sample_valid_in; la = if_a.sample_left_in; ra = if_a.sample_right_in;
    vb = if_b.sample_valid_in; lb = if_b.sample_left_in; rb = if_b.sample_right_in;
    @(posedge clk);
    #1;
    model_edge(0, va, la, ra);
    model_edge(1, vb, lb, rb);
    for (int d = 0; d < 2; d++) begin
      o = dut_out(d);
      e = exp_out(d);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL out_%0d t=%0d got={bclk,lrcl,data,ready,fs,ur}=%b expected=%b", d, t[d], o, e);
      end
      if (o[1]) fs_cnt[d]++;
      if (o[0]) ur_cnt[d]++;
      dv = div_p[d];
      fl = 2 * dv * slot_p[d];
      if (t[d] % dv == dv / 2) cap[d] = {cap[d][62:0], o[3]};
      if (t[d] % fl == fl - dv / 2 && t[d] / fl < 8) got[d][t[d] / fl] = cap[d];
    end
    if (lrcl_a && first_lr < 0) first_lr = t[0];
  endtask

  task automatic rand_b();
    if_b.sample_valid_in = ($urandom_range(0, 255) == 0);
    if_b.sample_left_in  = 16'($urandom);
    if_b.sample_right_in = 16'($urandom);
  endtask

  task automatic run_until(input int target, input logic rnd_a, input logic rnd_b);
    while (t[0] < target) begin
      if (rnd_a) begin
        if_a.sample_valid_in = ($urandom_range(0, 4095) == 0);
        if_a.sample_left_in  = 16'($urandom);
        if_a.sample_right_in = 16'($urandom);
      end
      if (rnd_b) rand_b();
      step();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if_a.sample_valid_in = 1'b0;
    if_b.sample_valid_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      t[d] = 0; m_full[d] = 1'b0; m_sl[d] = '0; m_sr[d] = '0;
      cur_l[d] = '0; cur_r[d] = '0; fs_e[d] = 1'b0; ur_e[d] = 1'b0;
      cap[d] = '0; ur_cnt[d] = 0; fs_cnt[d] = 0;
      for (int f = 0; f < 8; f++) got[d][f] = '0;
      check($sformatf("reset_out_%0d", d), 64'(dut_out(d)), 64'(6'b000100));
    end
    first_lr = -1;
  endtask

  initial begin
    logic acc;
    int n;
    tbl[0] = '{l: 16'hA5C3, r: 16'h0F01, exp_frame: 64'hA5C3_0000_0F01_0000};
    tbl[1] = '{l: 16'h8000, r: 16'h0001, exp_frame: 64'h8000_0000_0001_0000};
    tbl[2] = '{l: 16'hFFFF, r: 16'h0000, exp_frame: 64'hFFFF_0000_0000_0000};
    tbl[3] = '{l: 16'h1234, r: 16'hFEDC, exp_frame: 64'h1234_0000_FEDC_0000};
    if_a.sample_left_in = '0; if_a.sample_right_in = '0; if_a.sample_valid_in = 1'b0;
    if_b.sample_left_in = '0; if_b.sample_right_in = '0; if_b.sample_valid_in = 1'b0;

    // idle dut_a for three frames; dut_b sends one 16'h8001 pair
    do_reset();
    if_b.sample_valid_in = 1'b1; if_b.sample_left_in = 16'h8001; if_b.sample_right_in = 16'h0000;
    step();
    if_b.sample_valid_in = 1'b0;
    run_until(3 * FL_A + 40, 1'b0, 1'b0);
    check("first_lrcl_rise", 64'(first_lr), 64'(31 * 32));
    check("idle_underruns", 64'(ur_cnt[0]), 64'd3);
    check("idle_frame_starts", 64'(fs_cnt[0]), 64'd3);
    check("idle_frame2_data", got[0][2], 64'h0);
    check("b_frame1", 64'(got[1][1][47:0]), 64'h8001_0000_0000);
    check("b_frame2", 64'(got[1][2][47:0]), 64'h0);

    // table vectors streamed with valid held high
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if_a.sample_valid_in = 1'b1;
      if_a.sample_left_in  = tbl[i].l;
      if_a.sample_right_in = tbl[i].r;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 3 * FL_A) begin
        acc = if_a.sample_ready_out;
        rand_b();
        step();
        n++;
      end
      check($sformatf("accept_wait_%0d", i), 64'(acc), 64'd1);
    end
    if_a.sample_valid_in = 1'b0;
    run_until(5 * FL_A - 8, 1'b0, 1'b1);
    for (int f = 1; f <= 4; f++) check($sformatf("table_frame_%0d", f), got[0][f], tbl[f-1].exp_frame);
    check("stream_underruns", 64'(ur_cnt[0]), 64'd0);
    check("stream_frame_starts", 64'(fs_cnt[0]), 64'd4);

    // first offer lands on the load edge itself
    do_reset();
    run_until(FL_A - 1, 1'b0, 1'b1);
    if_a.sample_valid_in = 1'b1; if_a.sample_left_in = 16'h6B2D; if_a.sample_right_in = 16'h9E47;
    step();
    if_a.sample_valid_in = 1'b0;
    check("loadedge_underrun", 64'(ur_cnt[0]), 64'd1);
    run_until(3 * FL_A - 8, 1'b0, 1'b1);
    check("loadedge_frame1", got[0][1], 64'h0);
    check("loadedge_frame2", got[0][2], 64'h6B2D_0000_9E47_0000);
    check("loadedge_underrun_total", 64'(ur_cnt[0]), 64'd1);

    // async reset mid right slot with a pair staged
    do_reset();
    if_a.sample_valid_in = 1'b1; if_a.sample_left_in = 16'h1111; if_a.sample_right_in = 16'h2222;
    step();
    if_a.sample_valid_in = 1'b0;
    run_until(FL_A, 1'b0, 1'b1);
    if_a.sample_valid_in = 1'b1; if_a.sample_left_in = 16'h3C3C; if_a.sample_right_in = 16'hC3C3;
    step();
    if_a.sample_valid_in = 1'b0;
    run_until(FL_A + 40 * 32 + 10, 1'b0, 1'b1);
    check("staged_before_reset", 64'(if_a.sample_ready_out), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_a", 64'(dut_out(0)), 64'(6'b000100));
    check("async_reset_b", 64'(dut_out(1)), 64'(6'b000100));
    do_reset();
    run_until(2 * FL_A - 8, 1'b0, 1'b0);
    check("post_reset_frame1", got[0][1], 64'h0);
    check("post_reset_underrun", 64'(ur_cnt[0]), 64'd1);

    // random traffic on both instances
    do_reset();
    run_until(4 * FL_A, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
